score_controller: RTL and testbench
===================================

Name: score_controller

Overview:
- Owns the game score as a BCD counter and arbitrates score-add requests from several game-logic sources.
- Requesters are asteroid hits, bonus pickups and level-complete.
- Adds one BCD digit per cycle with ripple carry.
- Publishes frame-stable digit values to the scoreboard digit drawing objects (one object per digit) via their bitmap lookup.

Parameters:
- NUM_REQ, 4, number of score-add requesters.
- NUM_DIGITS, 3, number of BCD score digits; digit 0 is least significant.
- SATURATE, 1, on carry-out of the top digit: 1 = clamp the score to all nines; 0 = wrap, keeping the low NUM_DIGITS digits.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  new-game pulse; zeroes the score
- req  in  NUM_REQ  per-requester add request, level-held until acked
- points  in  4*NUM_REQ  per-requester BCD addend; slice i belongs to req[i]
- ack  out  NUM_REQ  one-cycle grant/accept pulse, one-hot or zero
- startOfFrame  in  1  one-cycle pulse at VGA frame start
- displayDigits  out  4*NUM_DIGITS  frame-latched score for the digit objects
- busy  out  1  high while in ADD state
- overflow  out  1  sticky; set on top-digit carry-out
- highDigits  out  4*NUM_DIGITS  high score (see Optional Feature)

Behaviour:
- Reset: applies to all registers on the clk edge where reset=1. Score, displayDigits, highDigits, ack, busy and overflow go to 0; rrPtr=0; state=IDLE.
- FSM states are IDLE and ADD.
- IDLE, grant:
  - If any req bit is set, grant round-robin, searching from rrPtr upward with wrap.
  - Same cycle: ack[g]=1 (registered, visible the next cycle); addend <= points[g]; carry <= 0; idx <= 0; rrPtr <= g+1 mod NUM_REQ; go to ADD.
- ADD, one digit per cycle:
  - Compute s = score[idx] + addend + carry.
  - If s > 9: digit = s-10, carry = 1. Otherwise digit = s, carry = 0.
  - addend is forced to 0 after idx 0.
  - There is always exactly NUM_DIGITS ADD cycles, with no early exit.
- Top digit carry-out: overflow <= 1. If SATURATE=1, all digits <= 9; otherwise the wrapped digits are kept. Then return to IDLE.
- Throughput: at most one grant per NUM_DIGITS+1 cycles. busy is 1 exactly in ADD.
- Addend handling:
  - Values 10..15 are clamped to 9 at latch time.
  - points=0 is still granted and acked, leaving the score unchanged.
- clear:
  - Highest priority in any state: score, overflow and addend go to 0; state goes to IDLE; rrPtr is unchanged.
  - An ADD in progress is aborted; that request's points are lost, since it was already acked.
  - clear and req in the same cycle: no grant, no ack.
- reset and clear in the same cycle: reset wins.
- Display latch:
  - On startOfFrame with state==IDLE (and no clear in that cycle): displayDigits <= score.
  - On startOfFrame during ADD: no update; displayDigits holds until the next frame.
  - displayDigits never changes except on a startOfFrame cycle or on reset. It therefore never shows a partially carried score, and an aborted add is never displayed.
- req dropped before ack: allowed; no grant for that requester.

Optional Feature:
- Macro HIGH_SCORE_EN.
- Defined:
  - On a clear cycle, if score > highDigits (unsigned compare of the concatenated BCD), highDigits <= score before the score is zeroed.
  - highDigits is cleared only by reset.
- Undefined: highDigits is driven constant 0 and no compare logic is built; the port list is unchanged.

Decomposition:
- Package score_pkg holds:
  - typedef bcd_digit_t (logic [3:0]);
  - constant BCD_MAX = 4'd9;
  - enum score_state_t {IDLE, ADD}.
- One sub-module: bcd_digit_adder. It is combinational: a, b, cin in; sum and cout out; it handles the >9 correction.

Test Plan:
- Reset, then req[0]=1 with points[0]=7: ack[0] pulses once; busy is high 3 cycles; score=007; after the next startOfFrame, displayDigits=007.
- Score 095, add 8: ripple carry gives 103; overflow stays 0.
- req=4'b1111, all points=1, held: acks occur in order 0,1,2,3,0 at 4-cycle spacing; score increments by 1 each grant.
- SATURATE=1, score 995, add 9: score=999 and overflow=1. Repeat with SATURATE=0: score=004 and overflow=1.
- startOfFrame during ADD: displayDigits unchanged. startOfFrame pulse in IDLE two cycles after ADD completes: updates displayDigits.
- Score 250, HIGH_SCORE_EN defined, clear asserted mid-ADD: highDigits=250, score=000, overflow=0. Then score 100 and clear: highDigits stays 250.

Source files
------------

// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types and constants for the score controller
package score_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic {IDLE, ADD} score_state_t;

endpackage

// File: rtl/bcd_digit_adder.sv
// rtl/bcd_digit_adder.sv - single BCD digit adder with decimal carry correction
module bcd_digit_adder
  import score_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t sum,
  output logic       cout
);

  logic [4:0] raw;

  // binary sum, folded back into 0..9 with a decimal carry when it exceeds nine
  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    if (raw > 5'd9) begin
      sum  = 4'(raw - 5'd10);
      cout = 1'b1;
    end else begin
      sum  = raw[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/score_controller.sv
// rtl/score_controller.sv - round-robin score-add arbiter and ripple BCD score (option: HIGH_SCORE_EN)
module score_controller
  import score_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int NUM_DIGITS = 3,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [4*NUM_REQ-1:0]    points,
  output logic [NUM_REQ-1:0]      ack,
  input  logic                    startOfFrame,
  output logic [4*NUM_DIGITS-1:0] displayDigits,
  output logic                    busy,
  output logic                    overflow,
  output logic [4*NUM_DIGITS-1:0] highDigits
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  score_state_t                   state;
  bcd_digit_t [NUM_DIGITS-1:0]    score;
  bcd_digit_t                     addend;
  logic                           carry;
  logic [IDX_W-1:0]               idx;
  logic [PTR_W-1:0]               rr_ptr;

  bcd_digit_t                     pts [NUM_REQ];
  logic                           grant_valid;
  logic [PTR_W-1:0]               grant_idx;
  logic [PTR_W-1:0]               cand;
  bcd_digit_t                     sum_digit;
  logic                           sum_carry;

  // split the packed points bus into one BCD addend per requester
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pts[i] = points[4*i +: 4];
    end
  end

  // round-robin search starting at rr_ptr, first requester found wins
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  bcd_digit_adder u_digit_adder (
    .a    (score[idx]),
    .b    (addend),
    .cin  (carry),
    .sum  (sum_digit),
    .cout (sum_carry)
  );

  // arbitration, digit-serial add, abort on clear and frame-stable display latch
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      score         <= '0;
      addend        <= '0;
      carry         <= 1'b0;
      idx           <= '0;
      rr_ptr        <= '0;
      ack           <= '0;
      busy          <= 1'b0;
      overflow      <= 1'b0;
      displayDigits <= '0;
    end else if (clear) begin
      // an in-flight add is dropped; its requester was already acked
      state    <= IDLE;
      score    <= '0;
      addend   <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      ack      <= '0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      ack <= '0;
      if (startOfFrame && state == IDLE) begin
        displayDigits <= score;
      end
      case (state)
        IDLE: begin
          if (grant_valid) begin
            ack    <= NUM_REQ'(1) << grant_idx;
            addend <= (pts[grant_idx] > BCD_MAX) ? BCD_MAX : pts[grant_idx];
            carry  <= 1'b0;
            idx    <= '0;
            rr_ptr <= PTR_W'((int'(grant_idx) + 1) % NUM_REQ);
            state  <= ADD;
            busy   <= 1'b1;
          end
        end
        ADD: begin
          score[idx] <= sum_digit;
          carry      <= sum_carry;
          addend     <= '0;
          idx        <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (sum_carry) begin
              overflow <= 1'b1;
              if (SATURATE) begin
                for (int d = 0; d < NUM_DIGITS; d++) begin
                  score[d] <= BCD_MAX;
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HIGH_SCORE_EN
  logic [4*NUM_DIGITS-1:0] high_q;

  // capture the finishing score on new-game if it beats the record
  always_ff @(posedge clk) begin
    if (reset) begin
      high_q <= '0;
    end else if (clear && (score > high_q)) begin
      high_q <= score;
    end
  end

  assign highDigits = high_q;
`else
  assign highDigits = '0;
`endif

endmodule

// File: tb/tb_score_controller.sv
// tb/tb_score_controller.sv - scoreboard bench for score_controller (saturating and wrapping builds)
module tb_score_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        startOfFrame;
  logic [3:0]  req;
  logic [3:0]  pts_tb [4];
  logic [15:0] points;
  logic [3:0]  ack, ack_w;
  logic [11:0] displayDigits, disp_w;
  logic        busy, busy_w;
  logic        overflow, ovf_w;
  logic [11:0] highDigits, high_w;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          model = 0;
  int          model_w = 0;
  logic [11:0] exp_q [$];
  logic [11:0] exp_high;

  assign points = {pts_tb[3], pts_tb[2], pts_tb[1], pts_tb[0]};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  score_controller #(.NUM_REQ(4), .NUM_DIGITS(3), .SATURATE(1'b1)) dut (
    .clk(clk), .reset(reset), .clear(clear), .req(req), .points(points),
    .ack(ack), .startOfFrame(startOfFrame), .displayDigits(displayDigits),
    .busy(busy), .overflow(overflow), .highDigits(highDigits)
  );

  score_controller #(.NUM_REQ(4), .NUM_DIGITS(3), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset(reset), .clear(clear), .req(req), .points(points),
    .ack(ack_w), .startOfFrame(startOfFrame), .displayDigits(disp_w),
    .busy(busy_w), .overflow(ovf_w), .highDigits(high_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; clear = 1'b0; req = '0; startOfFrame = 1'b0;
    for (int i = 0; i < 4; i++) pts_tb[i] = '0;
    @(negedge clk);
    reset = 1'b0;
    model = 0; model_w = 0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model = 0; model_w = 0;
  endtask

  // request, wait for ack, release, wait for the add to finish, update the model
  task automatic add_req(input logic [1:0] i, input logic [3:0] p, output int bc, output int na);
    int n;
    int cl;
    req[i] = 1'b1;
    pts_tb[i] = p;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 4'b0 && n < 20);
    check("ack_grant", {28'b0, ack}, 32'(4'b0001 << i));
    req[i] = 1'b0;
    na = (ack != 4'b0) ? 1 : 0;
    bc = 0;
    while (busy && bc < 20) begin
      bc++;
      @(negedge clk);
      if (ack != 4'b0) na++;
    end
    cl = (p > 4'd9) ? 9 : int'(p);
    model   = (model + cl > 999) ? 999 : model + cl;
    model_w = (model_w + cl) % 1000;
  endtask

  task automatic build(input int target);
    int bc, na, step;
    while (model < target) begin
      step = (target - model > 9) ? 15 : target - model;
      add_req(2'd3, 4'(step), bc, na);
    end
  endtask

  task automatic frame(input string tag);
    exp_q.push_back(to_bcd(model));
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    check(tag, {20'b0, displayDigits}, {20'b0, exp_q.pop_front()});
  endtask

  initial begin
    int bc, na, n;
    int last_cyc;
    logic [11:0] held;

`ifdef HIGH_SCORE_EN
    exp_high = 12'h250;
`else
    exp_high = 12'h000;
`endif

    // reset state
    do_reset();
    check("rst_display", {20'b0, displayDigits}, 32'h0);
    check("rst_ack", {28'b0, ack}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_overflow", {31'b0, overflow}, 32'h0);
    check("rst_high", {20'b0, highDigits}, 32'h0);

    // first add: single ack pulse, three busy cycles, then displayed
    add_req(2'd0, 4'd7, bc, na);
    check("add7_busy_cycles", 32'(bc), 32'd3);
    check("add7_ack_pulses", 32'(na), 32'd1);
    frame("display_007");

    // ripple carry 095 + 8, built partly with clamped addends
    build(95);
    frame("display_095");
    add_req(2'd1, 4'd8, bc, na);
    frame("display_103");
    check("ovf_after_103", {31'b0, overflow}, 32'h0);

    // zero addend is still acked and leaves the score alone
    add_req(2'd2, 4'd0, bc, na);
    check("zero_ack_pulses", 32'(na), 32'd1);
    frame("display_zero_add");

    // frame pulse during ADD must not update the display
    held = displayDigits;
    req[0] = 1'b1; pts_tb[0] = 4'd2;
    n = 0;
    do begin @(negedge clk); n++; end while (ack == 4'b0 && n < 20);
    check("sof_add_ack", {28'b0, ack}, 32'h1);
    req[0] = 1'b0;
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    check("sof_during_add", {20'b0, displayDigits}, {20'b0, held});
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    model = model + 2; model_w = model_w + 2;
    @(negedge clk);
    check("display_held_idle", {20'b0, displayDigits}, {20'b0, held});
    frame("display_105");

    // round-robin with all requesters held
    do_reset();
    for (int i = 0; i < 4; i++) pts_tb[i] = 4'd1;
    req = 4'hF;
    last_cyc = 0;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (ack == 4'b0 && n < 20);
      check("rr_order", {28'b0, ack}, 32'(4'b0001 << (g % 4)));
      if (g > 0) check("rr_spacing", 32'(cyc - last_cyc), 32'd4);
      last_cyc = cyc;
      if (g == 4) req = 4'h0;
    end
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    model = 5; model_w = 5;
    frame("display_rr_005");

    // top-digit carry: clamp on the saturating build, wrap on the other
    do_clear();
    check("clear_ovf", {31'b0, overflow}, 32'h0);
    build(995);
    frame("display_995");
    add_req(2'd0, 4'd9, bc, na);
    frame("display_sat_999");
    check("ovf_sat", {31'b0, overflow}, 32'h1);
    check("display_wrap_004", {20'b0, disp_w}, {20'b0, to_bcd(model_w)});
    check("ovf_wrap", {31'b0, ovf_w}, 32'h1);

    // clear mid-ADD records high score and aborts the add
    do_reset();
    build(250);
    req[1] = 1'b1; pts_tb[1] = 4'd5;
    n = 0;
    do begin @(negedge clk); n++; end while (ack == 4'b0 && n < 20);
    check("abort_ack", {28'b0, ack}, 32'h2);
    req[1] = 1'b0;
    do_clear();
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_ovf", {31'b0, overflow}, 32'h0);
    check("high_250", {20'b0, highDigits}, {20'b0, exp_high});
    frame("display_abort_000");

    // clear and req together: no ack that cycle
    req[2] = 1'b1; pts_tb[2] = 4'd1;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_req_no_ack", {28'b0, ack}, 32'h0);
    add_req(2'd2, 4'd1, bc, na);
    frame("display_001");

    // lower score on clear keeps the record
    build(100);
    frame("display_100");
    do_clear();
    check("high_kept", {20'b0, highDigits}, {20'b0, exp_high});
    frame("display_cleared");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
